// File: rtl/ps2_mouse_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_packetizer
// Purpose  : Assembles 3-byte standard PS/2 mouse packets from a byte stream,
//            accumulates X/Y deltas with 9-bit saturation and presents
//            rate-limited updates to the ADB mouse handler.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            clk_en           - clock enable; all state advances only when high
//            ps2_byte/strobe  - received byte and its valid flag
//            mouseStrobe      - one-clk_en-cycle pulse, update valid
//            mouseX/mouseY    - signed 9-bit deltas since the previous strobe
//            mouseButton      - left button, 1 = pressed
//            sync_err         - pulse when a byte/partial packet is dropped
// Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_packetizer #(
    parameter logic [16:0] EMIT_INTERVAL = 17'd16000,
    parameter logic [16:0] BYTE_TIMEOUT  = 17'd16000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_strobe,
    output logic       mouseStrobe,
    output logic [8:0] mouseX,
    output logic [8:0] mouseY,
    output logic       mouseButton,
    output logic       sync_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B1   = 2'd1,
        ST_B2   = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [4:0]  flags_q,    flags_d;     // {Yovf, Xovf, Ysign, Xsign, L}
    logic [7:0]  xbyte_q,    xbyte_d;
    logic [16:0] to_cnt_q,   to_cnt_d;
    logic [16:0] emit_cnt_q, emit_cnt_d;
    logic [8:0]  acc_x_q,    acc_x_d;
    logic [8:0]  acc_y_q,    acc_y_d;
    logic        btn_q,      btn_d;
    logic        pending_q,  pending_d;
    logic        strobe_q,   strobe_d;
    logic [8:0]  out_x_q,    out_x_d;
    logic [8:0]  out_y_q,    out_y_d;
    logic        out_btn_q,  out_btn_d;
    logic        sync_err_q, sync_err_d;

    // Overflow forces the extreme value in the direction of the sign bit.
    function automatic logic [8:0] delta9(input logic ovf, input logic sign,
                                          input logic [7:0] mag);
        if (ovf) begin
            return sign ? 9'h100 : 9'h0FF;
        end
        return {sign, mag};
    endfunction

    // A 10-bit sum overflows 9 bits exactly when its top two bits differ.
    function automatic logic [8:0] sat9(input logic [9:0] s);
        if (s[9] != s[8]) begin
            return s[9] ? 9'h100 : 9'h0FF;
        end
        return s[8:0];
    endfunction

    logic       w_emit;
    logic       w_commit;
    logic [8:0] w_dx;
    logic [8:0] w_dy;
    logic [8:0] w_base_x;
    logic [8:0] w_base_y;
    logic [9:0] w_sum_x;
    logic [9:0] w_sum_y;
    logic       w_last_btn;

    assign w_emit   = (emit_cnt_q == EMIT_INTERVAL) && pending_q;
    assign w_commit = ps2_strobe && (state_q == ST_B2);
    assign w_dx     = delta9(flags_q[3], flags_q[1], xbyte_q);
    assign w_dy     = delta9(flags_q[4], flags_q[2], ps2_byte);

    // A packet committing on the emit cycle lands in freshly cleared
    // accumulators and is compared against the button being emitted now.
    assign w_base_x   = w_emit ? 9'd0 : acc_x_q;
    assign w_base_y   = w_emit ? 9'd0 : acc_y_q;
    assign w_last_btn = w_emit ? btn_q : out_btn_q;
    assign w_sum_x    = {w_base_x[8], w_base_x} + {w_dx[8], w_dx};
    assign w_sum_y    = {w_base_y[8], w_base_y} + {w_dy[8], w_dy};

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        xbyte_d    = xbyte_q;
        to_cnt_d   = to_cnt_q;
        emit_cnt_d = emit_cnt_q;
        acc_x_d    = acc_x_q;
        acc_y_d    = acc_y_q;
        btn_d      = btn_q;
        pending_d  = pending_q;
        strobe_d   = strobe_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        out_btn_d  = out_btn_q;
        sync_err_d = sync_err_q;

        if (clk_en) begin
            strobe_d   = 1'b0;
            sync_err_d = 1'b0;

            // Packet framing and inter-byte timeout
            if (ps2_strobe) begin
                to_cnt_d = 17'd0;
                case (state_q)
                    ST_IDLE: begin
                        if (ps2_byte[3]) begin
                            flags_d = {ps2_byte[7:4], ps2_byte[0]};
                            state_d = ST_B1;
                        end else begin
                            sync_err_d = 1'b1;
                        end
                    end
                    ST_B1: begin
                        xbyte_d = ps2_byte;
                        state_d = ST_B2;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (to_cnt_q == BYTE_TIMEOUT) begin
                    state_d    = ST_IDLE;
                    to_cnt_d   = 17'd0;
                    sync_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 17'd1;
                end
            end else begin
                to_cnt_d = 17'd0;
            end

            // Rate-limited emission of the pre-commit accumulation
            if (w_emit) begin
                strobe_d   = 1'b1;
                out_x_d    = acc_x_q;
                out_y_d    = acc_y_q;
                out_btn_d  = btn_q;
                acc_x_d    = 9'd0;
                acc_y_d    = 9'd0;
                pending_d  = 1'b0;
                emit_cnt_d = 17'd0;
            end else if (emit_cnt_q != EMIT_INTERVAL) begin
                emit_cnt_d = emit_cnt_q + 17'd1;
            end

            // Packet commit (third byte)
            if (w_commit) begin
                acc_x_d = sat9(w_sum_x);
                acc_y_d = sat9(w_sum_y);
                btn_d   = flags_q[0];
                if ((w_dx != 9'd0) || (w_dy != 9'd0) || (flags_q[0] != w_last_btn)) begin
                    pending_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            flags_q    <= 5'd0;
            xbyte_q    <= 8'd0;
            to_cnt_q   <= 17'd0;
            emit_cnt_q <= 17'd0;
            acc_x_q    <= 9'd0;
            acc_y_q    <= 9'd0;
            btn_q      <= 1'b0;
            pending_q  <= 1'b0;
            strobe_q   <= 1'b0;
            out_x_q    <= 9'd0;
            out_y_q    <= 9'd0;
            out_btn_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            xbyte_q    <= xbyte_d;
            to_cnt_q   <= to_cnt_d;
            emit_cnt_q <= emit_cnt_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            btn_q      <= btn_d;
            pending_q  <= pending_d;
            strobe_q   <= strobe_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            out_btn_q  <= out_btn_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign mouseStrobe = strobe_q;
    assign mouseX      = out_x_q;
    assign mouseY      = out_y_q;
    assign mouseButton = out_btn_q;
    assign sync_err    = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_mouse_packetizer
// Purpose  : Self-checking bench for ps2_mouse_packetizer: packet table,
//            directed corner sequences and randomized traffic against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_packetizer;

    localparam int EI = 40;
    localparam int BT = 20;

    logic       clk;
    logic       reset;
    logic       clk_en;
    logic [7:0] ps2_byte;
    logic       ps2_strobe;
    logic       mouseStrobe;
    logic [8:0] mouseX;
    logic [8:0] mouseY;
    logic       mouseButton;
    logic       sync_err;

    ps2_mouse_packetizer #(
        .EMIT_INTERVAL(17'(EI)),
        .BYTE_TIMEOUT (17'(BT))
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .ps2_byte   (ps2_byte),
        .ps2_strobe (ps2_strobe),
        .mouseStrobe(mouseStrobe),
        .mouseX     (mouseX),
        .mouseY     (mouseY),
        .mouseButton(mouseButton),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_print = 0;

    // Observation of DUT events since the last clear
    int         tick_no = 0;
    int         err_seen = 0;
    int         strobe_seen = 0;
    int         last_strobe_tick = 0;
    logic [8:0] cap_x = 9'd0;
    logic [8:0] cap_y = 9'd0;
    logic       cap_btn = 1'b0;

    // ---------------- behavioural model ----------------
    int         m_nb, m_idle, m_accx, m_accy, m_since;
    logic [7:0] m_pkt0, m_pkt1, m_pkt2;
    logic       m_btn, m_pend, m_obtn;
    logic       m_strobe, m_err;
    logic [8:0] m_x, m_y;

    function automatic int delta(input logic ovf, input logic sign, input logic [7:0] mag);
        if (ovf) return sign ? -256 : 255;
        return sign ? int'(mag) - 256 : int'(mag);
    endfunction

    function automatic int clamp9(input int v);
        if (v > 255)  return 255;
        if (v < -256) return -256;
        return v;
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic stb, input logic [7:0] b);
        int   dx;
        int   dy;
        logic commit;
        if (rst) begin
            m_nb = 0; m_idle = 0; m_accx = 0; m_accy = 0; m_since = 0;
            m_btn = 0; m_pend = 0; m_obtn = 0; m_strobe = 0; m_err = 0;
            m_x = 0; m_y = 0;
            return;
        end
        if (!en) return;
        m_strobe = 0;
        m_err    = 0;
        commit   = 0;
        if (stb) begin
            m_idle = 0;
            if (m_nb == 0) begin
                if (b[3]) begin m_pkt0 = b; m_nb = 1; end
                else m_err = 1;
            end else if (m_nb == 1) begin
                m_pkt1 = b; m_nb = 2;
            end else begin
                m_pkt2 = b; m_nb = 0; commit = 1;
            end
        end else if (m_nb != 0) begin
            m_idle++;
            if (m_idle > BT) begin m_nb = 0; m_idle = 0; m_err = 1; end
        end
        if (m_since >= EI && m_pend) begin
            m_strobe = 1;
            m_x = 9'(m_accx);
            m_y = 9'(m_accy);
            m_obtn = m_btn;
            m_accx = 0; m_accy = 0; m_pend = 0; m_since = 0;
        end else begin
            m_since++;
        end
        if (commit) begin
            dx = delta(m_pkt0[6], m_pkt0[4], m_pkt1);
            dy = delta(m_pkt0[7], m_pkt0[5], m_pkt2);
            m_accx = clamp9(m_accx + dx);
            m_accy = clamp9(m_accy + dy);
            if (dx != 0 || dy != 0 || m_pkt0[0] != m_obtn) m_pend = 1;
            m_btn = m_pkt0[0];
        end
    endtask

    // ---------------- drive / check helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic tick(input logic rst, input logic en, input logic stb, input logic [7:0] b);
        reset = rst; clk_en = en; ps2_strobe = stb; ps2_byte = b;
        @(posedge clk);
        #1;
        model_step(rst, en, stb, b);
        n_vec++;
        if ({mouseStrobe, mouseX, mouseY, mouseButton, sync_err} !==
            {m_strobe, m_x, m_y, m_btn_out(), m_err}) begin
            n_bad++;
            if (n_print < 20) begin
                n_print++;
                $display("FAIL model t=%0t: got stb=%b x=%h y=%h btn=%b err=%b, want stb=%b x=%h y=%h btn=%b err=%b",
                         $time, mouseStrobe, mouseX, mouseY, mouseButton, sync_err,
                         m_strobe, m_x, m_y, m_obtn, m_err);
            end
        end
        if (rst) begin
            tick_no = 0;
        end else if (en) begin
            tick_no++;
            if (sync_err) err_seen++;
            if (mouseStrobe) begin
                strobe_seen++;
                last_strobe_tick = tick_no;
                cap_x = mouseX; cap_y = mouseY; cap_btn = mouseButton;
            end
        end
    endtask

    function automatic logic m_btn_out();
        return m_obtn;
    endfunction

    task automatic clear_obs();
        err_seen = 0; strobe_seen = 0; last_strobe_tick = 0;
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b1, 1'b0, 8'h00);
        clear_obs();
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b0, 1'b1, 1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic wait_strobe(input int bound);
        for (int k = 0; k < bound && strobe_seen == 0; k++) tick(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    // ---------------- packet table ----------------
    typedef struct {
        logic       has_junk;
        logic [7:0] junk;
        logic [7:0] b0, b1, b2;
        int         reps;
        logic [8:0] ex, ey;
        logic       ebtn;
        int         eerr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        reset = 1'b1; clk_en = 1'b0; ps2_strobe = 1'b0; ps2_byte = 8'h00;
        m_nb = 0; m_idle = 0; m_accx = 0; m_accy = 0; m_since = 0;
        m_btn = 0; m_pend = 0; m_obtn = 0; m_strobe = 0; m_err = 0; m_x = 0; m_y = 0;
        m_pkt0 = 0; m_pkt1 = 0; m_pkt2 = 0;

        tbl[0] = '{1'b0, 8'h00, 8'h28, 8'h05, 8'hFD, 1, 9'h005, 9'h1FD, 1'b0, 0};
        tbl[1] = '{1'b1, 8'h00, 8'h09, 8'h0A, 8'h00, 1, 9'h00A, 9'h000, 1'b1, 1};
        tbl[2] = '{1'b0, 8'h00, 8'h18, 8'h80, 8'h00, 3, 9'h100, 9'h000, 1'b0, 0};
        tbl[3] = '{1'b0, 8'h00, 8'h48, 8'h00, 8'h00, 1, 9'h0FF, 9'h000, 1'b0, 0};
        tbl[4] = '{1'b0, 8'h00, 8'h88, 8'h00, 8'h00, 1, 9'h000, 9'h0FF, 1'b0, 0};
        tbl[5] = '{1'b0, 8'h00, 8'hB8, 8'h10, 8'h00, 1, 9'h110, 9'h100, 1'b0, 0};
        tbl[6] = '{1'b0, 8'h00, 8'h08, 8'h7F, 8'h80, 3, 9'h0FF, 9'h0FF, 1'b0, 0};
        tbl[7] = '{1'b0, 8'h00, 8'h38, 8'h01, 8'hFF, 2, 9'h100, 9'h1FE, 1'b0, 0};
        tbl[8] = '{1'b0, 8'h00, 8'h09, 8'h00, 8'h00, 1, 9'h000, 9'h000, 1'b1, 0};

        repeat (2) @(posedge clk);
        do_reset();
        check("reset_strobe", 32'(mouseStrobe), 32'd0);
        check("reset_x", 32'(mouseX), 32'd0);
        check("reset_y", 32'(mouseY), 32'd0);
        check("reset_btn", 32'(mouseButton), 32'd0);
        check("reset_err", 32'(sync_err), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (tbl[i].has_junk) send(tbl[i].junk);
            for (int r = 0; r < tbl[i].reps; r++) begin
                send(tbl[i].b0); send(tbl[i].b1); send(tbl[i].b2);
                idle(1);
            end
            wait_strobe(2 * EI);
            check($sformatf("tbl%0d_strobe", i), 32'(strobe_seen), 32'd1);
            check($sformatf("tbl%0d_x", i), 32'(cap_x), 32'(tbl[i].ex));
            check($sformatf("tbl%0d_y", i), 32'(cap_y), 32'(tbl[i].ey));
            check($sformatf("tbl%0d_btn", i), 32'(cap_btn), 32'(tbl[i].ebtn));
            check($sformatf("tbl%0d_err", i), 32'(err_seen), 32'(tbl[i].eerr));
            idle(EI + 10);
            check($sformatf("tbl%0d_single", i), 32'(strobe_seen), 32'd1);
            check($sformatf("tbl%0d_hold_x", i), 32'(mouseX), 32'(tbl[i].ex));
        end

        // Partial packet abandoned by timeout
        do_reset();
        send(8'h08); send(8'h05);
        idle(BT + 3);
        check("timeout_err", 32'(err_seen), 32'd1);
        send(8'h08); send(8'h01); send(8'h02);
        wait_strobe(2 * EI);
        check("timeout_strobe", 32'(strobe_seen), 32'd1);
        check("timeout_x", 32'(cap_x), 32'h001);
        check("timeout_y", 32'(cap_y), 32'h002);
        check("timeout_err_total", 32'(err_seen), 32'd1);

        // Packet committed on the exact emit cycle
        do_reset();
        send(8'h08); send(8'h03); send(8'h00);
        idle(EI - 5);
        send(8'h08); send(8'h02); send(8'h00);
        check("coincide_first_tick", 32'(last_strobe_tick), 32'(EI + 1));
        check("coincide_first_x", 32'(cap_x), 32'h003);
        clear_obs();
        wait_strobe(3 * EI);
        check("coincide_second_tick", 32'(last_strobe_tick), 32'(2 * EI + 2));
        check("coincide_second_x", 32'(cap_x), 32'h002);

        // Commit while the interval counter is already saturated
        do_reset();
        idle(49);
        send(8'h08); send(8'h04); send(8'h00);
        idle(1);
        check("late_tick", 32'(last_strobe_tick), 32'd53);
        check("late_x", 32'(cap_x), 32'h004);

        // Reset while waiting for the Y byte
        do_reset();
        send(8'h09); send(8'h06); send(8'h01);
        wait_strobe(2 * EI);
        check("pre_reset_x", 32'(cap_x), 32'h006);
        send(8'h08); send(8'h05);
        do_reset();
        idle(EI + 10);
        check("b2_reset_strobe", 32'(strobe_seen), 32'd0);
        check("b2_reset_x", 32'(mouseX), 32'd0);
        check("b2_reset_y", 32'(mouseY), 32'd0);
        check("b2_reset_btn", 32'(mouseButton), 32'd0);

        // Bytes offered while clk_en is low are ignored
        do_reset();
        tick(1'b0, 1'b0, 1'b1, 8'h08);
        tick(1'b0, 1'b0, 1'b1, 8'h07);
        tick(1'b0, 1'b0, 1'b1, 8'h00);
        idle(EI + 10);
        check("noen_strobe", 32'(strobe_seen), 32'd0);
        check("noen_err", 32'(err_seen), 32'd0);

        // Randomized traffic against the model
        do_reset();
        begin
            int         gap;
            logic       en_r;
            logic [7:0] b;
            gap = 0;
            for (int i = 0; i < 4000; i++) begin
                en_r = ($urandom_range(0, 9) != 0);
                b    = 8'($urandom);
                if ($urandom_range(0, 499) == 0) begin
                    tick(1'b1, 1'b1, 1'b0, 8'h00);
                end else if (!en_r) begin
                    tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), b);
                end else if (gap > 0) begin
                    gap--;
                    tick(1'b0, 1'b1, 1'b0, b);
                end else begin
                    if (m_nb == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
                    tick(1'b0, 1'b1, 1'b1, b);
                    gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(BT + 5, BT + 15))
                                                      : int'($urandom_range(0, 6));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
